// File: rtl/aes_inv_round_iterator.sv
// Iterative AES-128 inverse cipher: forward key expansion to K10, then ten
// inverse rounds at one per clock with round keys regenerated backward.

module aes_gf_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] b;
    p = '0;
    b = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ b;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] acc;

  // a^254 via repeated squaring; naturally maps 0 to 0
  always_comb begin
    sq  = a;
    acc = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    y = acc;
  end
endmodule

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;

  aes_gf_inv u_inv (.a(a), .y(b));

  assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
           ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] b;

  assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.a(b), .y(y));
endmodule

module aes_inv_round_iterator #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plain_out,
  output logic         busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] KEXP = 2'd1;
  localparam logic [1:0] DEC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [3:0] LAST = 4'(NR);

  logic [1:0]   state;
  logic [127:0] data_reg;
  logic [127:0] key_reg;
  logic [127:0] plain_reg;
  logic [3:0]   rnd;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int unsigned i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] shifted, inv_sub, ark, imc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      localparam int DST = r + 4 * c;
      assign shifted[127-8*DST -: 8] = data_reg[127-8*SRC -: 8];
      aes_inv_sbox u_isb (.a(shifted[127-8*DST -: 8]), .y(inv_sub[127-8*DST -: 8]));
    end
  end

  assign ark = inv_sub ^ key_reg;
  assign imc = {inv_mix_col(ark[127:96]), inv_mix_col(ark[95:64]),
                inv_mix_col(ark[63:32]),  inv_mix_col(ark[31:0])};

  logic [31:0] w0, w1, w2, w3, iw1, iw2, iw3;
  logic [31:0] sw_in, sw_rot, sw_out, rc_word, nw0, nw1, nw2, nw3;
  logic [3:0]  rc_idx;

  assign {w0, w1, w2, w3} = key_reg;
  assign iw3 = w3 ^ w2;
  assign iw2 = w2 ^ w1;
  assign iw1 = w1 ^ w0;

  // The four forward S-boxes are shared by the forward and backward schedules
  assign sw_in   = (state == KEXP) ? w3 : iw3;
  assign sw_rot  = {sw_in[23:0], sw_in[31:24]};
  assign rc_idx  = (state == KEXP) ? rnd + 4'd1 : rnd;
  assign rc_word = {rcon(rc_idx), 24'h000000};

  for (genvar k = 0; k < 4; k++) begin : g_sw
    aes_sbox u_sb (.a(sw_rot[31-8*k -: 8]), .y(sw_out[31-8*k -: 8]));
  end

  assign nw0 = w0 ^ sw_out ^ rc_word;
  assign nw1 = w1 ^ nw0;
  assign nw2 = w2 ^ nw1;
  assign nw3 = w3 ^ nw2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_reg  <= '0;
      key_reg   <= '0;
      plain_reg <= '0;
      rnd       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_reg <= cipher_in;
          key_reg  <= key_in;
          rnd      <= '0;
          state    <= KEXP;
        end
        KEXP: begin
          key_reg <= {nw0, nw1, nw2, nw3};
          rnd     <= rnd + 4'd1;
          if (rnd == LAST - 4'd1) state <= DEC;
        end
        DEC: begin
          if (rnd == LAST) begin
            data_reg <= data_reg ^ key_reg;
            key_reg  <= {nw0, iw1, iw2, iw3};
            rnd      <= rnd - 4'd1;
          end else if (rnd != 4'd0) begin
            data_reg <= imc;
            key_reg  <= {nw0, iw1, iw2, iw3};
            rnd      <= rnd - 4'd1;
          end else begin
            data_reg  <= ark;
            plain_reg <= ark;
            state     <= DONE;
          end
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign plain_out = plain_reg;
endmodule

// File: tb/tb_aes_inv_round_iterator.sv
// Bench for aes_inv_round_iterator: a forward-AES model encrypts random
// plaintexts; the DUT must recover them with exact handshake timing.

module tb_aes_inv_round_iterator;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] cipher_in = '0;
  logic [127:0] key_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] plain_out;
  logic [127:0] drv_exp = '0;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  aes_inv_round_iterator #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_in(cipher_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .plain_out(plain_out), .busy(busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference AES (forward cipher) ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk, res;
    rk = round_key(key, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      rk = round_key(key, rd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- transaction-level model ----------------
  bit           model_live = 1'b0;
  bit           pending = 1'b0;
  int           cyc = 0;
  int           acc = 0;
  logic [127:0] exp_pt = '0;
  logic [127:0] exp_k10 = '0;
  logic [127:0] plain_exp = '0;

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1'b1;
      pending    = 1'b0;
      plain_exp  = '0;
    end else if (model_live) begin
      if (pending) begin
        if (cyc - acc >= 21 && out_ready) pending = 1'b0;
        else if (cyc + 1 - acc == 21) plain_exp = exp_pt;
      end else if (in_valid) begin
        pending = 1'b1;
        acc     = cyc + 1;
        exp_pt  = drv_exp;
        exp_k10 = round_key(key_in, 10);
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("in_ready", {127'd0, in_ready}, {127'd0, !pending});
      check("busy", {127'd0, busy}, {127'd0, pending});
      check("out_valid", {127'd0, out_valid}, {127'd0, pending && (cyc - acc >= 21)});
      check("plain_out", plain_out, plain_exp);
      if (pending && cyc - acc == 10) check("key_reg_k10", dut.key_reg, exp_k10);
    end
  end

  // ---------------- driver ----------------
  task automatic offer(input logic [127:0] ct, input logic [127:0] key,
                       input logic [127:0] pt, output int a);
    @(negedge clk);
    in_valid  = 1'b1;
    cipher_in = ct;
    key_in    = key;
    drv_exp   = pt;
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("accept_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    a = cyc;
  endtask

  task automatic wait_valid(input int a, output int lat);
    @(negedge clk);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    if (!out_valid) check("valid_timeout", {127'd0, out_valid}, 128'd1);
    lat = cyc - a;
  endtask

  task automatic take(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a1, a2, lat;
    logic [127:0] rk, rp, rc;

    build_sbox();
    check("model_c1_ct", encrypt(C1_PT, C1_KEY), C1_CT);
    check("model_c1_k10", round_key(C1_KEY, 10), C1_K10);
    check("model_b_ct", encrypt(B_PT, B_KEY), B_CT);
    check("model_b_k10", round_key(B_KEY, 10), B_K10);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_plain", plain_out, 128'd0);

    // C.1 with garbage offered while busy
    offer(C1_CT, C1_KEY, C1_PT, a1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      drv_exp   = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(a1, lat);
    check("c1_latency", 128'(lat), 128'd21);
    check("c1_plain", plain_out, C1_PT);
    take(3);

    // App. B with 50 cycles of backpressure and a competing offer
    offer(B_CT, B_KEY, B_PT, a1);
    in_valid = 1'b0;
    wait_valid(a1, lat);
    check("b_plain", plain_out, B_PT);
    for (int k = 0; k < 50; k++) begin
      in_valid  = 1'b1;
      cipher_in = {$urandom, $urandom, $urandom, $urandom};
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    check("bp_plain_held", plain_out, B_PT);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_in_ready", {127'd0, in_ready}, 128'd1);
    check("bp_idle_out_valid", {127'd0, out_valid}, 128'd0);

    // reset sampled at E15 of a C.1 run
    offer(C1_CT, C1_KEY, C1_PT, a1);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("mid_rst_plain", plain_out, 128'd0);
    offer(B_CT, B_KEY, B_PT, a1);
    in_valid = 1'b0;
    wait_valid(a1, lat);
    check("post_rst_plain", plain_out, B_PT);
    take(0);

    // back-to-back with in_valid held and out_ready tied high
    out_ready = 1'b1;
    offer(C1_CT, C1_KEY, C1_PT, a1);
    cipher_in = B_CT;
    key_in    = B_KEY;
    drv_exp   = B_PT;
    wait_valid(a1, lat);
    check("b2b_c1_plain", plain_out, C1_PT);
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    a2 = cyc;
    in_valid = 1'b0;
    check("b2b_accept_gap", 128'(a2 - a1), 128'd23);
    wait_valid(a2, lat);
    check("b2b_b_plain", plain_out, B_PT);
    @(negedge clk);
    out_ready = 1'b0;

    // random keys and plaintexts
    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      rc = encrypt(rp, rk);
      offer(rc, rk, rp, a1);
      in_valid = 1'b0;
      wait_valid(a1, lat);
      check("rand_latency", 128'(lat), 128'd21);
      take(int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
